// File: rtl/axi_rd_arb_pkg.sv
// Shared AXI read-channel widths, response codes and arbiter state encodings.
package axi_rd_arb_pkg;

   localparam int AXI_ID_WIDTH     = 4;
   localparam int AXI_ADDR_WIDTH   = 32;
   localparam int AXI_LEN_WIDTH    = 8;
   localparam int AXI_SIZE_WIDTH   = 3;
   localparam int AXI_BURST_WIDTH  = 2;
   localparam int AXI_LOCK_WIDTH   = 1;
   localparam int AXI_CACHE_WIDTH  = 4;
   localparam int AXI_PROT_WIDTH   = 3;
   localparam int AXI_QOS_WIDTH    = 4;
   localparam int AXI_REGION_WIDTH = 4;
   localparam int AXI_DATA_WIDTH   = 32;
   localparam int AXI_RESP_WIDTH   = 2;

   localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_RD_ARB_IDLE = 2'd0;
   localparam logic [1:0] AXI_RD_ARB_AR   = 2'd1;
   localparam logic [1:0] AXI_RD_ARB_R    = 2'd2;
   localparam logic [1:0] AXI_RD_ARB_ERR  = 2'd3;

   // Index width that stays legal for a single master.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_rd_arb_rr_arbiter.sv
// One-hot round-robin grant: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   logic found;
   int   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found     = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx   = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/axi_rd_arb.sv
// AXI4 read arbiter: round-robin over NUM_MST masters, one burst in flight,
// out-of-window reads answered locally with DECERR.
// Handshakes: a transfer happens on a rising edge where valid && ready; a
// source holds valid and payload stable until then, ready may depend on valid.
module axi_rd_arb
   import axi_rd_arb_pkg::*;
#(
   parameter int                        NUM_MST   = 2,
   parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SIZE = 32'h0001_0000
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_MST-1:0]                    mst_arvalid,
   output logic [NUM_MST-1:0]                    mst_arready,
   input  logic [NUM_MST*AXI_ID_WIDTH-1:0]       mst_arid,
   input  logic [NUM_MST*AXI_ADDR_WIDTH-1:0]     mst_araddr,
   input  logic [NUM_MST*AXI_LEN_WIDTH-1:0]      mst_arlen,
   input  logic [NUM_MST*AXI_SIZE_WIDTH-1:0]     mst_arsize,
   input  logic [NUM_MST*AXI_BURST_WIDTH-1:0]    mst_arburst,
   input  logic [NUM_MST*AXI_LOCK_WIDTH-1:0]     mst_arlock,
   input  logic [NUM_MST*AXI_CACHE_WIDTH-1:0]    mst_arcache,
   input  logic [NUM_MST*AXI_PROT_WIDTH-1:0]     mst_arprot,
   input  logic [NUM_MST*AXI_QOS_WIDTH-1:0]      mst_arqos,
   input  logic [NUM_MST*AXI_REGION_WIDTH-1:0]   mst_arregion,
   output logic [NUM_MST-1:0]                    mst_rvalid,
   input  logic [NUM_MST-1:0]                    mst_rready,
   output logic [AXI_ID_WIDTH-1:0]               mst_rid,
   output logic [AXI_DATA_WIDTH-1:0]             mst_rdata,
   output logic [AXI_RESP_WIDTH-1:0]             mst_rresp,
   output logic                                  mst_rlast,
   output logic                                  slv_arvalid,
   input  logic                                  slv_arready,
   output logic [AXI_ID_WIDTH-1:0]               slv_arid,
   output logic [AXI_ADDR_WIDTH-1:0]             slv_araddr,
   output logic [AXI_LEN_WIDTH-1:0]              slv_arlen,
   output logic [AXI_SIZE_WIDTH-1:0]             slv_arsize,
   output logic [AXI_BURST_WIDTH-1:0]            slv_arburst,
   output logic [AXI_LOCK_WIDTH-1:0]             slv_arlock,
   output logic [AXI_CACHE_WIDTH-1:0]            slv_arcache,
   output logic [AXI_PROT_WIDTH-1:0]             slv_arprot,
   output logic [AXI_QOS_WIDTH-1:0]              slv_arqos,
   output logic [AXI_REGION_WIDTH-1:0]           slv_arregion,
   input  logic                                  slv_rvalid,
   output logic                                  slv_rready,
   input  logic [AXI_ID_WIDTH-1:0]               slv_rid,
   input  logic [AXI_DATA_WIDTH-1:0]             slv_rdata,
   input  logic [AXI_RESP_WIDTH-1:0]             slv_rresp,
   input  logic                                  slv_rlast,
   output logic [1:0]                            dbg_state
);

   localparam int PW = ptr_width(NUM_MST);
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_MST - 1);

   logic [1:0]               state;
   logic [PW-1:0]            rr_ptr, g, gnt_idx, next_ptr;
   logic [NUM_MST-1:0]       gnt;
   logic [AXI_LEN_WIDTH-1:0] beat;
   logic                     ar_hs, in_win;
   int                       sel;

   logic [AXI_ID_WIDTH-1:0]     sel_id;
   logic [AXI_ADDR_WIDTH-1:0]   sel_addr, addr_off;
   logic [AXI_LEN_WIDTH-1:0]    sel_len;
   logic [AXI_SIZE_WIDTH-1:0]   sel_size;
   logic [AXI_BURST_WIDTH-1:0]  sel_burst;
   logic [AXI_LOCK_WIDTH-1:0]   sel_lock;
   logic [AXI_CACHE_WIDTH-1:0]  sel_cache;
   logic [AXI_PROT_WIDTH-1:0]   sel_prot;
   logic [AXI_QOS_WIDTH-1:0]    sel_qos;
   logic [AXI_REGION_WIDTH-1:0] sel_region;

   rr_arbiter #(.N(NUM_MST), .PW(PW)) u_rr (
      .req     (mst_arvalid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel        = int'(gnt_idx);
      sel_id     = mst_arid    [sel*AXI_ID_WIDTH     +: AXI_ID_WIDTH];
      sel_addr   = mst_araddr  [sel*AXI_ADDR_WIDTH   +: AXI_ADDR_WIDTH];
      sel_len    = mst_arlen   [sel*AXI_LEN_WIDTH    +: AXI_LEN_WIDTH];
      sel_size   = mst_arsize  [sel*AXI_SIZE_WIDTH   +: AXI_SIZE_WIDTH];
      sel_burst  = mst_arburst [sel*AXI_BURST_WIDTH  +: AXI_BURST_WIDTH];
      sel_lock   = mst_arlock  [sel*AXI_LOCK_WIDTH   +: AXI_LOCK_WIDTH];
      sel_cache  = mst_arcache [sel*AXI_CACHE_WIDTH  +: AXI_CACHE_WIDTH];
      sel_prot   = mst_arprot  [sel*AXI_PROT_WIDTH   +: AXI_PROT_WIDTH];
      sel_qos    = mst_arqos   [sel*AXI_QOS_WIDTH    +: AXI_QOS_WIDTH];
      sel_region = mst_arregion[sel*AXI_REGION_WIDTH +: AXI_REGION_WIDTH];
   end

   // Modular subtraction makes addresses below the base wrap high and fail.
   assign addr_off    = sel_addr - ADDR_BASE;
   assign in_win      = addr_off < ADDR_SIZE;
   assign ar_hs       = (state == AXI_RD_ARB_IDLE) && !rst && (|mst_arvalid);
   assign mst_arready = ar_hs ? gnt : '0;
   assign slv_arvalid = (state == AXI_RD_ARB_AR);
   assign next_ptr    = (g == LAST_IDX) ? '0 : g + PW'(1);
   assign dbg_state   = state;

   always_comb begin
      mst_rvalid = '0;
      slv_rready = 1'b0;
      mst_rid    = '0;
      mst_rdata  = '0;
      mst_rresp  = AXI_RESP_OKAY;
      mst_rlast  = 1'b0;
      case (state)
         AXI_RD_ARB_R: begin
            mst_rvalid[g] = slv_rvalid;
            slv_rready    = mst_rready[g];
            mst_rid       = slv_rid;
            mst_rdata     = slv_rdata;
            mst_rresp     = slv_rresp;
            mst_rlast     = slv_rlast;
         end
         AXI_RD_ARB_ERR: begin
            mst_rvalid[g] = 1'b1;
            mst_rid       = slv_arid;
            mst_rresp     = AXI_RESP_DECERR;
            mst_rlast     = (beat == slv_arlen);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= AXI_RD_ARB_IDLE;
         rr_ptr       <= '0;
         g            <= '0;
         beat         <= '0;
         slv_arid     <= '0;
         slv_araddr   <= '0;
         slv_arlen    <= '0;
         slv_arsize   <= '0;
         slv_arburst  <= '0;
         slv_arlock   <= '0;
         slv_arcache  <= '0;
         slv_arprot   <= '0;
         slv_arqos    <= '0;
         slv_arregion <= '0;
      end else begin
         case (state)
            AXI_RD_ARB_IDLE: begin
               if (ar_hs) begin
                  g            <= gnt_idx;
                  beat         <= '0;
                  slv_arid     <= sel_id;
                  slv_araddr   <= sel_addr;
                  slv_arlen    <= sel_len;
                  slv_arsize   <= sel_size;
                  slv_arburst  <= sel_burst;
                  slv_arlock   <= sel_lock;
                  slv_arcache  <= sel_cache;
                  slv_arprot   <= sel_prot;
                  slv_arqos    <= sel_qos;
                  slv_arregion <= sel_region;
                  state        <= in_win ? AXI_RD_ARB_AR : AXI_RD_ARB_ERR;
               end
            end
            AXI_RD_ARB_AR: begin
               if (slv_arready) state <= AXI_RD_ARB_R;
            end
            AXI_RD_ARB_R: begin
               if (slv_rvalid && mst_rready[g] && slv_rlast) begin
                  rr_ptr <= next_ptr;
                  state  <= AXI_RD_ARB_IDLE;
               end
            end
            AXI_RD_ARB_ERR: begin
               if (mst_rready[g]) begin
                  if (beat == slv_arlen) begin
                     rr_ptr <= next_ptr;
                     beat   <= '0;
                     state  <= AXI_RD_ARB_IDLE;
                  end else begin
                     beat <= beat + AXI_LEN_WIDTH'(1);
                  end
               end
            end
            default: state <= AXI_RD_ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb with two masters and a scripted slave.
module tb_axi_rd_arb;
   import axi_rd_arb_pkg::*;

   localparam int N = 2;

   logic             clk, rst;
   logic [N-1:0]     mst_arvalid, mst_arready, mst_rvalid, mst_rready;
   logic [N*4-1:0]   mst_arid, mst_arcache, mst_arqos, mst_arregion;
   logic [N*32-1:0]  mst_araddr;
   logic [N*8-1:0]   mst_arlen;
   logic [N*3-1:0]   mst_arsize, mst_arprot;
   logic [N*2-1:0]   mst_arburst;
   logic [N-1:0]     mst_arlock;
   logic [3:0]       mst_rid;
   logic [31:0]      mst_rdata;
   logic [1:0]       mst_rresp;
   logic             mst_rlast;
   logic             slv_arvalid, slv_arready;
   logic [3:0]       slv_arid, slv_arcache, slv_arqos, slv_arregion;
   logic [31:0]      slv_araddr;
   logic [7:0]       slv_arlen;
   logic [2:0]       slv_arsize, slv_arprot;
   logic [1:0]       slv_arburst;
   logic [0:0]       slv_arlock;
   logic             slv_rvalid, slv_rready, slv_rlast;
   logic [3:0]       slv_rid;
   logic [31:0]      slv_rdata;
   logic [1:0]       slv_rresp;
   logic [1:0]       dbg_state;

   logic [31:0] exp_q[$];
   int tests, fails;

   axi_rd_arb #(.NUM_MST(N)) dut (
      .clk(clk), .rst(rst),
      .mst_arvalid(mst_arvalid), .mst_arready(mst_arready),
      .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen),
      .mst_arsize(mst_arsize), .mst_arburst(mst_arburst), .mst_arlock(mst_arlock),
      .mst_arcache(mst_arcache), .mst_arprot(mst_arprot), .mst_arqos(mst_arqos),
      .mst_arregion(mst_arregion),
      .mst_rvalid(mst_rvalid), .mst_rready(mst_rready), .mst_rid(mst_rid),
      .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
      .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_arid(slv_arid),
      .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
      .slv_arburst(slv_arburst), .slv_arlock(slv_arlock), .slv_arcache(slv_arcache),
      .slv_arprot(slv_arprot), .slv_arqos(slv_arqos), .slv_arregion(slv_arregion),
      .slv_rvalid(slv_rvalid), .slv_rready(slv_rready), .slv_rid(slv_rid),
      .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
      .dbg_state(dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drivers
   task automatic set_ar(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
      mst_arid[m*4 +: 4]    = id;
      mst_araddr[m*32 +: 32] = addr;
      mst_arlen[m*8 +: 8]   = len;
      mst_arsize[m*3 +: 3]  = 3'd2;
      mst_arburst[m*2 +: 2] = 2'b01;
      mst_arvalid[m]        = 1'b1;
   endtask

   task automatic ar_accept(input int m, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len);
      #1 chk("arready_grant", mst_arready, 64'(1 << m));
      tick();
      mst_arvalid[m] = 1'b0;
      #1;
      chk("slv_arvalid", slv_arvalid, 1);
      chk("slv_araddr", slv_araddr, addr);
      chk("slv_arid", slv_arid, id);
      chk("slv_arlen", slv_arlen, len);
   endtask

   task automatic slave_accept();
      slv_arready = 1'b1;
      tick();
      slv_arready = 1'b0;
   endtask

   task automatic slave_burst(input int m, input logic [7:0] len, input logic [3:0] id,
                              input logic [31:0] base);
      for (int i = 0; i <= int'(len); i++) begin
         slv_rvalid = 1'b1;
         slv_rid    = id;
         slv_rdata  = base + 32'(i);
         slv_rresp  = 2'b00;
         slv_rlast  = (i == int'(len));
         mst_rready[m] = 1'b1;
         exp_q.push_back(base + 32'(i));
         #1;
         chk("r_valid", mst_rvalid, 64'(1 << m));
         chk("r_data", mst_rdata, exp_q.pop_front());
         chk("r_last", mst_rlast, (i == int'(len)));
         chk("r_id", mst_rid, id);
         chk("r_resp", mst_rresp, 0);
         tick();
      end
      slv_rvalid = 1'b0;
      slv_rlast  = 1'b0;
      mst_rready = '0;
      #1 chk("burst_done_idle", dbg_state, AXI_RD_ARB_IDLE);
   endtask

   initial begin
      int beat, cyc;
      tests = 0; fails = 0;
      rst = 1'b1;
      mst_arvalid = '0; mst_rready = '0;
      mst_arid = '0; mst_araddr = '0; mst_arlen = '0; mst_arsize = '0;
      mst_arburst = '0; mst_arlock = '0; mst_arcache = '0; mst_arprot = '0;
      mst_arqos = '0; mst_arregion = '0;
      slv_arready = 1'b0; slv_rvalid = 1'b0; slv_rid = '0; slv_rdata = '0;
      slv_rresp = '0; slv_rlast = 1'b0;
      repeat (2) tick();
      chk("rst_arready", mst_arready, 0);
      chk("rst_rvalid", mst_rvalid, 0);
      chk("rst_slv_arvalid", slv_arvalid, 0);
      chk("rst_slv_rready", slv_rready, 0);
      chk("rst_slv_araddr", slv_araddr, 0);
      chk("rst_rdata", mst_rdata, 0);
      chk("rst_state", dbg_state, AXI_RD_ARB_IDLE);
      rst = 1'b0;
      tick();

      // Single master burst
      set_ar(0, 4'd5, 32'h100, 8'd3);
      ar_accept(0, 4'd5, 32'h100, 8'd3);
      chk("ar_state", dbg_state, AXI_RD_ARB_AR);
      slave_accept();
      slave_burst(0, 8'd3, 4'd5, 32'hA0);

      // Simultaneous requests from reset, then a repeated conflict
      rst = 1'b1; tick(); rst = 1'b0;
      set_ar(0, 4'd1, 32'h110, 8'd0);
      set_ar(1, 4'd2, 32'h120, 8'd0);
      ar_accept(0, 4'd1, 32'h110, 8'd0);
      chk("loser_blocked", mst_arready, 0);
      slave_accept();
      slave_burst(0, 8'd0, 4'd1, 32'hB0);
      set_ar(0, 4'd3, 32'h130, 8'd0);
      ar_accept(1, 4'd2, 32'h120, 8'd0);
      slave_accept();
      slave_burst(1, 8'd0, 4'd2, 32'hC0);
      ar_accept(0, 4'd3, 32'h130, 8'd0);
      slave_accept();
      slave_burst(0, 8'd0, 4'd3, 32'hD0);

      // Out-of-window read completes locally with DECERR
      set_ar(0, 4'd7, 32'h0002_0000, 8'd1);
      #1 chk("err_arready", mst_arready, 2'b01);
      tick();
      mst_arvalid[0] = 1'b0;
      mst_rready[0]  = 1'b1;
      #1;
      chk("err_state", dbg_state, AXI_RD_ARB_ERR);
      chk("err_no_slv_ar", slv_arvalid, 0);
      chk("err_slv_rready", slv_rready, 0);
      chk("err_b0_valid", mst_rvalid, 2'b01);
      chk("err_b0_resp", mst_rresp, 2'b11);
      chk("err_b0_data", mst_rdata, 0);
      chk("err_b0_id", mst_rid, 7);
      chk("err_b0_last", mst_rlast, 0);
      tick();
      chk("err_b1_valid", mst_rvalid, 2'b01);
      chk("err_b1_resp", mst_rresp, 2'b11);
      chk("err_b1_last", mst_rlast, 1);
      chk("err_b1_no_slv_ar", slv_arvalid, 0);
      tick();
      mst_rready = '0;
      #1;
      chk("err_done_idle", dbg_state, AXI_RD_ARB_IDLE);
      chk("err_done_rvalid", mst_rvalid, 0);

      // Backpressure on master1: rready toggles 1/0
      set_ar(1, 4'd9, 32'h200, 8'd3);
      ar_accept(1, 4'd9, 32'h200, 8'd3);
      slave_accept();
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h60 + 32'(i));
      beat = 0;
      cyc = 0;
      while (beat < 4 && cyc < 16) begin
         slv_rvalid    = 1'b1;
         slv_rid       = 4'd9;
         slv_rdata     = 32'h60 + 32'(beat);
         slv_rlast     = (beat == 3);
         mst_rready[1] = (cyc % 2 == 0);
         #1;
         chk("bp_rready_mirror", slv_rready, mst_rready[1]);
         chk("bp_rvalid", mst_rvalid, 2'b10);
         if (mst_rready[1]) begin
            chk("bp_data_order", mst_rdata, exp_q.pop_front());
            beat++;
         end
         tick();
         cyc++;
      end
      chk("bp_all_beats", exp_q.size(), 0);
      chk("bp_cycles", cyc, 7);
      slv_rvalid = 1'b0; slv_rlast = 1'b0; mst_rready = '0;
      #1 chk("bp_idle", dbg_state, AXI_RD_ARB_IDLE);

      // Slave stalls AR for 5 cycles
      set_ar(0, 4'd2, 32'h300, 8'd0);
      ar_accept(0, 4'd2, 32'h300, 8'd0);
      set_ar(1, 4'd4, 32'h340, 8'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_arvalid", slv_arvalid, 1);
         chk("stall_araddr", slv_araddr, 32'h300);
         chk("stall_arid", slv_arid, 2);
         chk("stall_arready", mst_arready, 0);
      end
      mst_arvalid[1] = 1'b0;
      slave_accept();
      slave_burst(0, 8'd0, 4'd2, 32'h50);

      // Reset during beat 2 of 4, then a normal read
      set_ar(0, 4'd6, 32'h400, 8'd3);
      ar_accept(0, 4'd6, 32'h400, 8'd3);
      slave_accept();
      for (int i = 0; i < 2; i++) begin
         slv_rvalid = 1'b1; slv_rid = 4'd6; slv_rdata = 32'hE0 + 32'(i);
         slv_rlast = 1'b0; mst_rready[0] = 1'b1;
         tick();
      end
      slv_rdata = 32'hE2;
      #1 chk("rst_mid_beat2", mst_rdata, 32'hE2);
      rst = 1'b1;
      tick();
      slv_rvalid = 1'b0; slv_rdata = '0; slv_rid = '0; mst_rready = '0;
      #1;
      chk("rstmid_rvalid", mst_rvalid, 0);
      chk("rstmid_slv_rready", slv_rready, 0);
      chk("rstmid_slv_arvalid", slv_arvalid, 0);
      chk("rstmid_slv_araddr", slv_araddr, 0);
      chk("rstmid_rdata", mst_rdata, 0);
      chk("rstmid_state", dbg_state, AXI_RD_ARB_IDLE);
      rst = 1'b0;
      tick();
      set_ar(0, 4'd4, 32'h104, 8'd1);
      ar_accept(0, 4'd4, 32'h104, 8'd1);
      slave_accept();
      slave_burst(0, 8'd1, 4'd4, 32'hF0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
